// File: rtl/cpu_mem_arbiter_pkg.sv
// rtl/cpu_mem_arbiter_pkg.sv - shared encodings for the IF/MEM memory-port arbiter
package cpu_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - one-outstanding arbiter of fetch and data ports onto a shared memory port
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        inst_cancel,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    arb_state_t      state;
    owner_t          owner;
    logic            cancel_flag;
    logic [CW-1:0]   starve_cnt;
    logic            grant_inst;
    logic            in_req;
    logic            in_resp;

    assign grant_inst = inst_req && (!data_req || starve_cnt == STARVE_LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ARB_IDLE;
            owner       <= OWN_INST;
            cancel_flag <= 1'b0;
            starve_cnt  <= '0;
            mem_req     <= 1'b0;
            mem_wr      <= 1'b0;
            mem_size    <= 2'd0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
        end else begin
            if (!inst_req)
                starve_cnt <= '0;
            case (state)
                ARB_IDLE: begin
                    cancel_flag <= 1'b0;
                    if (inst_req || data_req) begin
                        state   <= ARB_REQ;
                        mem_req <= 1'b1;
                        if (grant_inst) begin
                            owner      <= OWN_INST;
                            mem_wr     <= 1'b0;
                            mem_size   <= SIZE_WORD;
                            mem_addr   <= inst_addr;
                            mem_wdata  <= 32'd0;
                            starve_cnt <= '0;
                        end else begin
                            owner     <= OWN_DATA;
                            mem_wr    <= data_wr;
                            mem_size  <= data_size;
                            mem_addr  <= data_addr;
                            mem_wdata <= data_wdata;
                            // only count grants that actually made a fetch wait
                            if (inst_req && starve_cnt != STARVE_LIM)
                                starve_cnt <= starve_cnt + CW'(1);
                        end
                    end
                end
                ARB_REQ: begin
                    if (inst_cancel && owner == OWN_INST)
                        cancel_flag <= 1'b1;
                    if (mem_addr_ok) begin
                        state   <= ARB_RESP;
                        mem_req <= 1'b0;
                    end
                end
                ARB_RESP: begin
                    if (inst_cancel && owner == OWN_INST)
                        cancel_flag <= 1'b1;
                    if (mem_data_ok) begin
                        state       <= ARB_IDLE;
                        cancel_flag <= 1'b0;
                    end
                end
                default: begin
                    state   <= ARB_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // handshake pulses are suppressed while reset is high so an aborted transaction never completes
    assign in_req  = (state == ARB_REQ)  && !reset;
    assign in_resp = (state == ARB_RESP) && !reset;

    assign inst_addr_ok = in_req  && owner == OWN_INST && mem_addr_ok;
    assign data_addr_ok = in_req  && owner == OWN_DATA && mem_addr_ok;
    assign inst_data_ok = in_resp && owner == OWN_INST && mem_data_ok && !cancel_flag && !inst_cancel;
    assign data_data_ok = in_resp && owner == OWN_DATA && mem_data_ok;

    assign inst_rdata = inst_data_ok ? mem_rdata : 32'd0;
    assign data_rdata = data_data_ok ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb/tb_cpu_mem_arbiter.sv - directed and randomized checks of cpu_mem_arbiter against a transaction model
module tb_cpu_mem_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int P_FREE = 0;
    localparam int P_REQ  = 1;
    localparam int P_RESP = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_cancel, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    cpu_mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inst_cancel(inst_cancel),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // transaction-level model: one outstanding transfer, who owns it, what it carries
    int          m_phase = P_FREE;
    logic        m_own_inst = 1'b0;
    logic        m_cancelled = 1'b0;
    int          m_waits = 0;
    logic        m_wr = 1'b0;
    logic [1:0]  m_size = 2'd0;
    logic [31:0] m_addr = 32'd0;
    logic [31:0] m_wdata = 32'd0;

    int          last_ia_cyc = -1;
    int          last_id_cyc = -1;
    int          n_inst_dok = 0;
    int          n_data_dok = 0;
    logic [31:0] last_irdata = 32'd0;
    logic        grant_log[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_size", mem_size, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_inst_addr_ok", inst_addr_ok, 0);
        check("rst_inst_data_ok", inst_data_ok, 0);
        check("rst_inst_rdata", inst_rdata, 0);
        check("rst_data_addr_ok", data_addr_ok, 0);
        check("rst_data_data_ok", data_data_ok, 0);
        check("rst_data_rdata", data_rdata, 0);
    endtask

    // one clock: check outputs against the model, advance the model, let requesters drop accepted requests
    task automatic cycle();
        logic e_ia, e_da, e_id, e_dd;
        #1;
        e_ia = !reset && m_phase == P_REQ && m_own_inst && mem_addr_ok;
        e_da = !reset && m_phase == P_REQ && !m_own_inst && mem_addr_ok;
        e_id = !reset && m_phase == P_RESP && m_own_inst && mem_data_ok && !m_cancelled && !inst_cancel;
        e_dd = !reset && m_phase == P_RESP && !m_own_inst && mem_data_ok;
        check("mem_req", mem_req, m_phase == P_REQ);
        if (m_phase == P_REQ) begin
            check("mem_wr", mem_wr, m_wr);
            check("mem_size", mem_size, m_size);
            check("mem_addr", mem_addr, m_addr);
            if (!m_own_inst) check("mem_wdata", mem_wdata, m_wdata);
        end
        check("inst_addr_ok", inst_addr_ok, e_ia);
        check("data_addr_ok", data_addr_ok, e_da);
        check("inst_data_ok", inst_data_ok, e_id);
        check("data_data_ok", data_data_ok, e_dd);
        if (e_id) check("inst_rdata", inst_rdata, mem_rdata);
        if (e_dd) check("data_rdata", data_rdata, mem_rdata);
        if (inst_addr_ok === 1'b1) begin last_ia_cyc = cyc; grant_log.push_back(1'b1); end
        if (data_addr_ok === 1'b1) grant_log.push_back(1'b0);
        if (inst_data_ok === 1'b1) begin last_id_cyc = cyc; n_inst_dok++; last_irdata = inst_rdata; end
        if (data_data_ok === 1'b1) n_data_dok++;
        @(posedge clk);
        if (reset) begin
            m_phase = P_FREE; m_waits = 0; m_cancelled = 1'b0;
        end else begin
            case (m_phase)
                P_FREE: begin
                    m_cancelled = 1'b0;
                    if (inst_req || data_req) begin
                        if (inst_req && (!data_req || m_waits >= STARVE_MAX)) begin
                            m_own_inst = 1'b1; m_wr = 1'b0; m_size = 2'd2; m_addr = inst_addr;
                            m_waits = 0;
                        end else begin
                            m_own_inst = 1'b0; m_wr = data_wr; m_size = data_size;
                            m_addr = data_addr; m_wdata = data_wdata;
                            if (inst_req) m_waits++;
                        end
                        m_phase = P_REQ;
                    end
                end
                P_REQ: begin
                    if (inst_cancel && m_own_inst) m_cancelled = 1'b1;
                    if (mem_addr_ok) m_phase = P_RESP;
                end
                default: begin
                    if (inst_cancel && m_own_inst) m_cancelled = 1'b1;
                    if (mem_data_ok) begin m_phase = P_FREE; m_cancelled = 1'b0; end
                end
            endcase
            if (!inst_req) m_waits = 0;
        end
        @(negedge clk);
        if (e_ia) inst_req = 1'b0;
        if (e_da) data_req = 1'b0;
        cyc++;
    endtask

    task automatic drain();
        int n = 0;
        reset = 1'b0; inst_cancel = 1'b0; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
        while (n < 200 && !(m_phase == P_FREE && !inst_req && !data_req)) begin
            cycle();
            n++;
        end
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    endtask

    task automatic raise_data(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata);
        data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wdata;
    endtask

    initial begin
        int t0, n0, d0;
        logic [5:0] pat;
        logic [31:0] held_addr, held_wdata;
        reset = 1'b1; inst_req = 1'b0; inst_addr = 32'd0; inst_cancel = 1'b0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs();

        // lone fetch
        t0 = cyc;
        inst_req = 1'b1; inst_addr = 32'hbfc00000;
        cycle();
        mem_addr_ok = 1'b1; cycle();
        mem_addr_ok = 1'b0; cycle(); cycle();
        mem_data_ok = 1'b1; mem_rdata = 32'h3c1d0000; cycle();
        mem_data_ok = 1'b0;
        check("fetch_addr_ok_cycle", last_ia_cyc - t0, 1);
        check("fetch_data_ok_cycle", last_id_cyc - t0, 4);
        check("fetch_rdata", last_irdata, 32'h3c1d0000);
        drain();

        // simultaneous store and fetch: data first
        grant_log.delete();
        inst_req = 1'b1; inst_addr = 32'hbfc00010;
        raise_data(1'b1, 2'd0, 32'h80000003, 32'h000000ab);
        cycle();
        check("store_mem_wr", mem_wr, 1);
        check("store_mem_size", mem_size, 0);
        check("store_mem_addr", mem_addr, 32'h80000003);
        drain();
        check("prio_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) check("prio_order", {grant_log[0], grant_log[1]}, 2'b01);

        // starvation limit
        grant_log.delete();
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
        inst_req = 1'b1; inst_addr = 32'h00400000;
        for (int i = 0; i < 20; i++) begin
            if (!data_req) raise_data(1'b0, 2'd2, $urandom & 32'hfffffffc, 32'd0);
            cycle();
        end
        data_req = 1'b0;
        drain();
        check("starve_grants_enough", grant_log.size() >= 6, 1);
        if (grant_log.size() >= 6) begin
            for (int i = 0; i < 6; i++) pat[i] = grant_log[i];
            check("starve_pattern", pat, 6'b010000);
        end

        // cancel during RESP
        n0 = n_inst_dok;
        inst_req = 1'b1; inst_addr = 32'hbfc00100;
        cycle();
        mem_addr_ok = 1'b1; cycle();
        mem_addr_ok = 1'b0; inst_cancel = 1'b1; cycle();
        inst_cancel = 1'b0; cycle();
        mem_data_ok = 1'b1; mem_rdata = 32'h12345678; cycle();
        mem_data_ok = 1'b0;
        check("cancel_suppressed", n_inst_dok - n0, 0);
        inst_req = 1'b1; inst_addr = 32'hbfc00104;
        drain();
        check("after_cancel_fetch", n_inst_dok - n0, 1);

        // reset in RESP of a data load
        d0 = n_data_dok;
        raise_data(1'b0, 2'd2, 32'h00001000, 32'd0);
        cycle();
        mem_addr_ok = 1'b1; cycle();
        mem_addr_ok = 1'b0; cycle();
        reset = 1'b1; mem_rdata = 32'hdeadbeef; cycle();
        reset = 1'b0;
        #1;
        check_reset_outputs();
        mem_data_ok = 1'b1; cycle();
        mem_data_ok = 1'b0; cycle();
        check("reset_no_data_ok", n_data_dok - d0, 0);

        // downstream fields hold while requester inputs move
        held_addr = 32'h80001234; held_wdata = 32'hcafef00d;
        raise_data(1'b1, 2'd2, held_addr, held_wdata);
        cycle();
        for (int i = 0; i < 10; i++) begin
            data_addr = $urandom; data_wdata = $urandom;
            cycle();
        end
        check("stable_mem_addr", mem_addr, held_addr);
        check("stable_mem_wdata", mem_wdata, held_wdata);
        drain();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (!inst_req && $urandom_range(0, 3) == 0) begin
                inst_req = 1'b1; inst_addr = $urandom & 32'hfffffffc;
            end
            if (!data_req && $urandom_range(0, 2) != 0)
                raise_data($urandom_range(0, 1) == 1, 2'($urandom_range(0, 2)), $urandom, $urandom);
            mem_addr_ok = $urandom_range(0, 2) != 0;
            mem_data_ok = $urandom_range(0, 1) == 1;
            mem_rdata = $urandom;
            inst_cancel = $urandom_range(0, 15) == 0;
            reset = $urandom_range(0, 399) == 0;
            cycle();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Arbitrates the instruction-fetch port (from the IF stage) and the data port (from the MEM stage) onto one shared SRAM-like memory port. One outstanding transaction at a time; data side has priority, with a starvation limit that guarantees fetch progress. Sits between the pipeline stages and the bus bridge, and lets IF discard an in-flight fetch on exception or ERET without corrupting the bus.

## Interface
- STARVE_MAX, default 4: consecutive data grants allowed while an inst request waits; the next grant then goes to inst.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- inst_req  in  1  fetch request, held until inst_addr_ok
- inst_addr  in  32  fetch address, word aligned
- inst_addr_ok  out  1  fetch request accepted
- inst_data_ok  out  1  fetch data valid
- inst_rdata  out  32  fetch data
- inst_cancel  in  1  drop the pending or in-flight fetch response
- data_req  in  1  load/store request, held until data_addr_ok
- data_wr  in  1  1 = store
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_addr  in  32  byte address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  load data valid / store complete
- data_rdata  out  32  load data
- mem_req  out  1  downstream request
- mem_wr  out  1  downstream write
- mem_size  out  2  downstream size
- mem_addr  out  32  downstream address
- mem_wdata  out  32  downstream write data
- mem_addr_ok  in  1  downstream accept
- mem_data_ok  in  1  downstream response
- mem_rdata  in  32  downstream read data

## Operation
- States: IDLE, REQ, RESP.
- IDLE: if a request is pending, pick a winner, latch owner and wr/size/addr/wdata (inst: wr=0, size=2) into registers, and go to REQ. With no request, stay in IDLE.
- Winner: data if data_req, unless starve_cnt == STARVE_MAX and inst_req, in which case inst.
- starve_cnt: increments on each data grant while inst_req=1 and saturates at STARVE_MAX. Clears on any inst grant and whenever inst_req=0.
- REQ: mem_req=1, driven from the latched fields. When mem_addr_ok=1, pulse the owner's *_addr_ok in the same cycle and go to RESP.
- RESP: mem_req=0. When mem_data_ok=1, pulse the owner's *_data_ok in the same cycle, pass mem_rdata through to the owner's rdata, and go to IDLE.
- Cancel: inst_cancel=1 during an inst-owned REQ or RESP sets cancel_flag.
  - The transaction completes downstream normally.
  - inst_data_ok is suppressed for it.
  - cancel_flag clears on return to IDLE.
  - inst_cancel in IDLE has no effect.
- mem_data_ok or mem_addr_ok outside the state that expects it: ignored.
- Reset, including mid-transaction: state=IDLE, starve_cnt=0, cancel_flag=0, all outputs 0. No data_ok is issued for the aborted transaction.

## Timing
- Grant latency: request seen in IDLE in cycle N; mem_req=1 from cycle N+1.
- Minimum transaction: 3 cycles (IDLE, REQ with immediate addr_ok, RESP with immediate data_ok). Back-to-back transactions are separated by one IDLE cycle.
- *_addr_ok and *_data_ok are single-cycle pulses, combinational from mem_addr_ok / mem_data_ok and gated by state, owner and cancel_flag.
- Downstream fields are registered and stay stable throughout REQ regardless of requester inputs.
- Requesters drop req the cycle after addr_ok. A request re-raised in the same cycle as data_ok is seen in the following IDLE cycle.
- inst_cancel and mem_data_ok in the same RESP cycle: inst_data_ok is suppressed.

## Structure
- The shared header holds the state encodings (ARB_IDLE/ARB_REQ/ARB_RESP = 2'd0/1/2), the size codes, and the owner codes (OWN_INST=0, OWN_DATA=1).
- Single module. The starvation counter is inline; no sub-modules.

## Test plan
- Lone fetch, inst_req at 0xbfc00000, mem_addr_ok immediate, mem_data_ok after 2 cycles with 0x3c1d0000 -> inst_addr_ok in cycle 2, inst_data_ok with rdata 0x3c1d0000 in cycle 5, mem_wr=0, mem_size=2.
- inst_req and data_req (store, size 0, addr 0x80000003, wdata 0xAB) raised together -> data granted first (mem_wr=1, mem_size=0), fetch granted after data_data_ok.
- data_req held continuously with inst_req pending and STARVE_MAX=4 -> exactly 4 data grants, then 1 inst grant, then data again.
- inst_cancel pulsed during the fetch's RESP -> mem_data_ok accepted and state returns to IDLE, inst_data_ok stays 0, next fetch proceeds normally.
- reset asserted in RESP of a data load -> next cycle all outputs 0, state IDLE; a later mem_data_ok produces no data_data_ok.
- mem_addr_ok held low for 10 cycles in REQ -> mem_addr/mem_wdata unchanged throughout while data_addr is toggled.
